// File: rtl/bluetooth_uart_tx.sv
// Configurable UART transmitter (baud, data width, parity, stop bits) for the
// HC-05/HC-06 link, fed by a ready/valid FIFO so whole messages can be queued.
module bluetooth_uart_tx #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_vld,
    output logic                          tx_rdy,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [3:0]       BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   FIFO_NONE = {(PTR_W + 1){1'b0}};

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_PAR   = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    // Odd parity makes the total count of ones odd, even parity makes it even.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] word);
        if (PARITY == 1) begin
            return ~^word;
        end else begin
            return ^word;
        end
    endfunction

    logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [PTR_W:0]       count_r;
    logic                 tx_rdy_r;
    logic [2:0]           state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [3:0]           bit_idx_r;
    logic                 stop_idx_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 par_r;
    logic                 tx_r;
    logic                 busy_r;

    logic                 empty_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 tick_s;
    logic [DATA_BITS-1:0] head_s;
    logic [PTR_W:0]       count_nxt_s;

    // FIFO handshake, bit-period tick and pop decision.
    always_comb begin
        empty_s = (count_r == FIFO_NONE);
        push_s  = tx_vld && tx_rdy_r;
        tick_s  = (cnt_r == CNT_LAST);
        head_s  = mem_r[rd_ptr_r];
        pop_s   = 1'b0;
        if (empty_s) begin
            pop_s = 1'b0;
        end else if (state_r == ST_IDLE) begin
            pop_s = 1'b1;
        end else if ((state_r == ST_STOP) && tick_s && (stop_idx_r == STOP_LAST)) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + 1'b1;
            2'b01:   count_nxt_s = count_r - 1'b1;
            default: count_nxt_s = count_r;
        endcase
    end

    // FIFO storage; stale contents are harmless because pointers reset.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= tx_data;
        end
    end

    // FIFO pointers, occupancy and ready flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= FIFO_NONE;
            tx_rdy_r <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            count_r  <= count_nxt_s;
            tx_rdy_r <= (count_nxt_s != FIFO_FULL);
        end
    end

    // Frame sequencer; the stop bit chains straight into the next start bit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            bit_idx_r  <= 4'd0;
            stop_idx_r <= 1'b0;
            shift_r    <= {DATA_BITS{1'b0}};
            par_r      <= 1'b0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= {CNT_W{1'b0}};
                    if (!empty_s) begin
                        shift_r <= head_s;
                        par_r   <= calc_parity(head_s);
                        tx_r    <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= ST_START;
                    end else begin
                        tx_r   <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tick_s) begin
                        cnt_r     <= {CNT_W{1'b0}};
                        tx_r      <= shift_r[0];
                        bit_idx_r <= 4'd0;
                        state_r   <= ST_DATA;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        cnt_r <= {CNT_W{1'b0}};
                        if (bit_idx_r == BIT_LAST) begin
                            if (PARITY != 0) begin
                                tx_r    <= par_r;
                                state_r <= ST_PAR;
                            end else begin
                                tx_r       <= 1'b1;
                                stop_idx_r <= 1'b0;
                                state_r    <= ST_STOP;
                            end
                        end else begin
                            bit_idx_r <= bit_idx_r + 1'b1;
                            tx_r      <= shift_r[1];
                            shift_r   <= shift_r >> 1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                ST_PAR: begin
                    if (tick_s) begin
                        cnt_r      <= {CNT_W{1'b0}};
                        tx_r       <= 1'b1;
                        stop_idx_r <= 1'b0;
                        state_r    <= ST_STOP;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tick_s) begin
                        cnt_r <= {CNT_W{1'b0}};
                        if (stop_idx_r == STOP_LAST) begin
                            stop_idx_r <= 1'b0;
                            if (!empty_s) begin
                                shift_r <= head_s;
                                par_r   <= calc_parity(head_s);
                                tx_r    <= 1'b0;
                                state_r <= ST_START;
                            end else begin
                                tx_r    <= 1'b1;
                                busy_r  <= 1'b0;
                                state_r <= ST_IDLE;
                            end
                        end else begin
                            stop_idx_r <= stop_idx_r + 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                default: begin
                    cnt_r   <= {CNT_W{1'b0}};
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx         = tx_r;
    assign busy       = busy_r;
    assign tx_rdy     = tx_rdy_r;
    assign fifo_count = count_r;

endmodule

// File: tb/tb_bluetooth_uart_tx.sv
// Bench for bluetooth_uart_tx: four configurations (8N1, 8E1, 8O1, 7N2) at DIV=10,
// a table of single frames, a scoreboard of queued words, and multi-cycle corner cases.
`timescale 1ns/1ps
module tb_bluetooth_uart_tx;

    localparam int DIV = 10;

    typedef struct {
        int         id;
        logic [8:0] data;
        logic       par;
    } exp_t;

    typedef struct {
        int         id;
        logic [8:0] data;
        logic       exp_par;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [3:0] vld;
    logic [8:0] din    [4];
    logic       tx_w   [4];
    logic       rdy_w  [4];
    logic       busy_w [4];
    logic [4:0] cnt_w  [4];

    int   tests_run;
    int   fail_cnt;
    exp_t exp_q [$];

    int nbits_t [4] = '{8, 8, 8, 7};
    int npar_t  [4] = '{0, 1, 1, 0};
    int nstop_t [4] = '{1, 1, 1, 2};

    bluetooth_uart_tx #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0),
                        .STOP_BITS(1), .FIFO_DEPTH(16)) u0 (
        .CLK(clk), .RST(rst), .tx_data(din[0][7:0]), .tx_vld(vld[0]), .tx_rdy(rdy_w[0]),
        .tx(tx_w[0]), .busy(busy_w[0]), .fifo_count(cnt_w[0]));
    bluetooth_uart_tx #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2),
                        .STOP_BITS(1), .FIFO_DEPTH(16)) u1 (
        .CLK(clk), .RST(rst), .tx_data(din[1][7:0]), .tx_vld(vld[1]), .tx_rdy(rdy_w[1]),
        .tx(tx_w[1]), .busy(busy_w[1]), .fifo_count(cnt_w[1]));
    bluetooth_uart_tx #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(1),
                        .STOP_BITS(1), .FIFO_DEPTH(16)) u2 (
        .CLK(clk), .RST(rst), .tx_data(din[2][7:0]), .tx_vld(vld[2]), .tx_rdy(rdy_w[2]),
        .tx(tx_w[2]), .busy(busy_w[2]), .fifo_count(cnt_w[2]));
    bluetooth_uart_tx #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(0),
                        .STOP_BITS(2), .FIFO_DEPTH(16)) u3 (
        .CLK(clk), .RST(rst), .tx_data(din[3][6:0]), .tx_vld(vld[3]), .tx_rdy(rdy_w[3]),
        .tx(tx_w[3]), .busy(busy_w[3]), .fifo_count(cnt_w[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; presents one word for the next rising edge.
    task automatic write(input int id, input logic [8:0] d, input logic p);
        check("accept_rdy", rdy_w[id], 1);
        din[id] = d;
        vld[id] = 1'b1;
        exp_q.push_back('{id, d, p});
        @(negedge clk);
        vld[id] = 1'b0;
    endtask

    // Samples the current negedge first; decodes one frame and scores it.
    task automatic rx_score(input int id, input int wait_max, input int exp_wait);
        int         waited;
        logic       bad;
        logic [8:0] word;
        logic       par;
        exp_t       e;
        waited = 0;
        while (tx_w[id] !== 1'b0 && waited < wait_max) begin
            waited++;
            @(negedge clk);
        end
        if (tx_w[id] !== 1'b0) begin
            check("rx_start", tx_w[id], 0);
        end else begin
            check("start_latency", waited, exp_wait);
            bad  = 1'b0;
            word = 9'd0;
            par  = 1'b0;
            for (int c = 1; c < DIV; c++) begin
                @(negedge clk);
                if (tx_w[id] !== 1'b0) bad = 1'b1;
            end
            for (int b = 0; b < nbits_t[id]; b++) begin
                for (int c = 0; c < DIV; c++) begin
                    @(negedge clk);
                    if (c == 0) word[b] = tx_w[id];
                    else if (tx_w[id] !== word[b]) bad = 1'b1;
                end
            end
            if (npar_t[id] != 0) begin
                for (int c = 0; c < DIV; c++) begin
                    @(negedge clk);
                    if (c == 0) par = tx_w[id];
                    else if (tx_w[id] !== par) bad = 1'b1;
                end
            end
            for (int c = 0; c < nstop_t[id] * DIV; c++) begin
                @(negedge clk);
                if (tx_w[id] !== 1'b1) bad = 1'b1;
            end
            check("bit_hold", bad, 0);
            check("stop_busy", busy_w[id], 1);
            if (exp_q.size() == 0) begin
                check("rx_unexpected_word", word, 9'h1FF);
            end else begin
                e = exp_q.pop_front();
                check("rx_data", word, e.data);
                check("rx_parity", par, e.par);
            end
        end
    endtask

    vec_t vecs [7];
    int   nacc;
    logic saw_full;
    logic saw_low;
    logic bad_idle;

    initial begin
        vecs[0] = '{0, 9'h055, 1'b0};
        vecs[1] = '{1, 9'h007, 1'b1};
        vecs[2] = '{2, 9'h007, 1'b0};
        vecs[3] = '{2, 9'h000, 1'b1};
        vecs[4] = '{0, 9'h0A3, 1'b0};
        vecs[5] = '{1, 9'h0FF, 1'b0};
        vecs[6] = '{3, 9'h05A, 1'b0};
        tests_run = 0;
        fail_cnt  = 0;
        rst = 1'b1;
        vld = 4'd0;
        for (int i = 0; i < 4; i++) din[i] = 9'd0;

        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i += 3) begin
            check("reset_tx", tx_w[i], 1);
            check("reset_rdy", rdy_w[i], 1);
            check("reset_busy", busy_w[i], 0);
            check("reset_count", cnt_w[i], 0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Single frames across all configurations.
        for (int v = 0; v < 7; v++) begin
            write(vecs[v].id, vecs[v].data, vecs[v].exp_par);
            check("tx_high_after_accept", tx_w[vecs[v].id], 1);
            check("busy_not_yet", busy_w[vecs[v].id], 0);
            check("count_one", cnt_w[vecs[v].id], 1);
            rx_score(vecs[v].id, 5, 1);
            @(negedge clk);
            check("end_busy", busy_w[vecs[v].id], 0);
            check("end_tx", tx_w[vecs[v].id], 1);
            check("end_count", cnt_w[vecs[v].id], 0);
        end

        // 7N2 back-to-back: stop high exactly 20 clocks, then the next start.
        write(3, 9'h041, 1'b0);
        write(3, 9'h042, 1'b0);
        rx_score(3, 5, 0);
        @(negedge clk);
        rx_score(3, 0, 0);
        @(negedge clk);
        check("b2b_end_busy", busy_w[3], 0);

        // FIFO full: vld held 20 clocks, words drained in order concurrently.
        nacc     = 0;
        saw_full = 1'b0;
        saw_low  = 1'b0;
        fork
            begin
                for (int k = 0; k < 20; k++) begin
                    din[0] = 9'(k);
                    vld[0] = 1'b1;
                    if (rdy_w[0]) begin
                        exp_q.push_back('{0, 9'(k), 1'b0});
                        nacc++;
                    end
                    @(negedge clk);
                    if (cnt_w[0] == 5'd16) saw_full = 1'b1;
                    if (!rdy_w[0]) saw_low = 1'b1;
                end
                vld[0] = 1'b0;
            end
            begin
                for (int f = 0; f < 17; f++) begin
                    rx_score(0, 5, (f == 0) ? 2 : 0);
                    if (f == 0) begin
                        check("rdy_low_before_pop", rdy_w[0], 0);
                        check("count_full", cnt_w[0], 16);
                    end
                    @(negedge clk);
                    if (f == 0) begin
                        check("rdy_back_after_pop", rdy_w[0], 1);
                        check("count_after_pop", cnt_w[0], 15);
                    end
                end
                check("full_end_busy", busy_w[0], 0);
            end
        join
        check("full_accepted", nacc, 17);
        check("full_saw_16", saw_full, 1);
        check("full_saw_rdy_low", saw_low, 1);

        // Reset during data bit 3 with three words queued.
        write(0, 9'h037, 1'b0);
        write(0, 9'h011, 1'b0);
        write(0, 9'h022, 1'b0);
        write(0, 9'h033, 1'b0);
        repeat (40) @(negedge clk);
        check("pre_reset_count", cnt_w[0], 3);
        check("pre_reset_bit3", tx_w[0], 0);
        rst = 1'b1;
        #1;
        check("rst_tx", tx_w[0], 1);
        check("rst_count", cnt_w[0], 0);
        check("rst_busy", busy_w[0], 0);
        check("rst_rdy", rdy_w[0], 1);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        bad_idle = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) bad_idle = 1'b1;
        end
        check("post_reset_idle", bad_idle, 0);
        write(0, 9'h05C, 1'b0);
        rx_score(0, 5, 1);
        @(negedge clk);
        check("post_reset_end_busy", busy_w[0], 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
